// File: rtl/mystic_pkg.sv
// Shared definitions for the mystic instruction fetch unit.
//   fetch_state_e : fetch FSM state encoding
//   UNCOMP_MARK   : low two bits that mark a 32-bit (uncompressed) instruction
package mystic_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ_LO  = 3'd1,
      WAIT_LO = 3'd2,
      REQ_HI  = 3'd3,
      WAIT_HI = 3'd4,
      DONE    = 3'd5
   } fetch_state_e;

   localparam logic [1:0] UNCOMP_MARK = 2'b11;

endpackage : mystic_pkg

// File: rtl/mystic_fetch_align.sv
// Halfword assembly and compressed-instruction detection (purely combinational).
// Ports:
//   rdata         : read data word currently returned by memory
//   half          : upper halfword kept from the first word of a word-crossing fetch
//   hi_phase      : rdata is the second word of a word-crossing fetch
//   upper_sel     : the instruction starts in the upper halfword of rdata (pc[1]=1)
//   instr         : assembled instruction, zero-extended when compressed
//   is_compressed : instruction is 16 bits wide
//   need_hi       : the upper halfword starts a 32-bit instruction; fetch the next word
module mystic_fetch_align
   import mystic_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [15:0] half,
   input  logic        hi_phase,
   input  logic        upper_sel,
   output logic [31:0] instr,
   output logic        is_compressed,
   output logic        need_hi
);

   always_comb begin
      instr         = '0;
      is_compressed = 1'b0;
      need_hi       = 1'b0;
      if (hi_phase) begin
         // Low half of the next word completes the instruction begun in the previous word.
         instr = {rdata[15:0], half};
      end else if (upper_sel) begin
         is_compressed = (rdata[17:16] != UNCOMP_MARK);
         need_hi       = ~is_compressed;
         instr         = {16'h0000, rdata[31:16]};
      end else begin
         is_compressed = (rdata[1:0] != UNCOMP_MARK);
         instr         = is_compressed ? {16'h0000, rdata[15:0]} : rdata;
      end
   end

endmodule : mystic_fetch_align

// File: rtl/mystic_instr_fetch.sv
// Instruction fetch unit: turns a single-cycle PC read pulse into one or two
// word reads on a req/gnt/rvalid memory port and returns the instruction,
// handling 16-bit compressed instructions and word-crossing 32-bit ones.
// Ports:
//   clk_i, rstn_i           : clock, asynchronous active-low reset
//   pc_i, pc_read_i         : fetch address and fetch request pulse
//   mem_req_o, mem_addr_o   : memory read request (held until granted), word address
//   mem_gnt_i               : request accepted
//   mem_rvalid_i, mem_rdata_i : read data return
//   instr_o, instr_pc_o     : fetched instruction and its PC (held until next ready)
//   is_compressed_o         : instr_o is a 16-bit instruction
//   instr_ready_o           : one-cycle result pulse
//   fetch_err_o             : misaligned PC or timeout; valid with instr_ready_o
module mystic_instr_fetch
   import mystic_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] pc_i,
   input  logic        pc_read_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        is_compressed_o,
   output logic        instr_ready_o,
   output logic        fetch_err_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   fetch_state_e state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [31:0] pc_q;
   logic [15:0] half_q;
   logic [31:0] instr_q, instr_pc_q;
   logic        comp_q, err_q;

   logic        ld_pc, ld_half, ld_res;
   logic [31:0] res_instr, res_pc;
   logic        res_comp, res_err;
   logic        timeout;

   logic [31:0] al_instr;
   logic        al_comp, al_need_hi;

   mystic_fetch_align u_align (
      .rdata         (mem_rdata_i),
      .half          (half_q),
      .hi_phase      (state_q == WAIT_HI),
      .upper_sel     (pc_q[1]),
      .instr         (al_instr),
      .is_compressed (al_comp),
      .need_hi       (al_need_hi)
   );

   assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
      ld_pc      = 1'b0;
      ld_half    = 1'b0;
      ld_res     = 1'b0;
      res_instr  = '0;
      res_comp   = 1'b0;
      res_err    = 1'b0;
      res_pc     = pc_q;
      wait_cnt_d = '0;

      case (state_q)
         IDLE: begin
            if (pc_read_i) begin
               ld_pc  = 1'b1;
               res_pc = pc_i;
               if (pc_i[0]) begin
                  state_d = DONE;
                  ld_res  = 1'b1;
                  res_err = 1'b1;
               end else begin
                  state_d = REQ_LO;
               end
            end
         end
         REQ_LO, REQ_HI: begin
            mem_req_o  = 1'b1;
            mem_addr_o = (state_q == REQ_HI) ? {pc_q[31:2] + 30'd1, 2'b00}
                                             : {pc_q[31:2], 2'b00};
            // A same-cycle rvalid is not looked at here: the grant alone moves us on.
            if (mem_gnt_i) begin
               state_d = (state_q == REQ_HI) ? WAIT_HI : WAIT_LO;
            end else if (timeout) begin
               state_d = DONE;
               ld_res  = 1'b1;
               res_err = 1'b1;
            end
         end
         WAIT_LO, WAIT_HI: begin
            if (mem_rvalid_i) begin
               if (state_q == WAIT_LO && al_need_hi) begin
                  state_d = REQ_HI;
                  ld_half = 1'b1;
               end else begin
                  state_d   = DONE;
                  ld_res    = 1'b1;
                  res_instr = al_instr;
                  res_comp  = al_comp;
               end
            end else if (timeout) begin
               state_d = DONE;
               ld_res  = 1'b1;
               res_err = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Counter restarts on every state change and counts while parked in REQ_*/WAIT_*.
      if (state_d == state_q && state_q != IDLE && state_q != DONE) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pc_q       <= '0;
         half_q     <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         comp_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (ld_pc) begin
            pc_q <= pc_i;
         end
         if (ld_half) begin
            half_q <= mem_rdata_i[31:16];
         end
         if (ld_res) begin
            instr_q    <= res_instr;
            instr_pc_q <= res_pc;
            comp_q     <= res_comp;
            err_q      <= res_err;
         end
      end
   end

   assign instr_o         = instr_q;
   assign instr_pc_o      = instr_pc_q;
   assign is_compressed_o = comp_q;
   assign instr_ready_o   = (state_q == DONE);
   assign fetch_err_o     = err_q & (state_q == DONE);

endmodule : mystic_instr_fetch

// File: tb/tb_mystic_instr_fetch.sv
// Directed bench for mystic_instr_fetch: a vector table of single fetches
// against a memory responder with immediate grant and 1-cycle data, plus
// hand-written timeout and reset-mid-fetch sequences.
module tb_mystic_instr_fetch;

   localparam int TO = 255;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic [31:0] pc_i;
   logic        pc_read_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        is_compressed_o;
   logic        instr_ready_o;
   logic        fetch_err_o;

   mystic_instr_fetch #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .pc_i            (pc_i),
      .pc_read_i       (pc_read_i),
      .mem_req_o       (mem_req_o),
      .mem_addr_o      (mem_addr_o),
      .mem_gnt_i       (mem_gnt_i),
      .mem_rvalid_i    (mem_rvalid_i),
      .mem_rdata_i     (mem_rdata_i),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .is_compressed_o (is_compressed_o),
      .instr_ready_o   (instr_ready_o),
      .fetch_err_o     (fetch_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] lo;        // data returned for the first access
      logic [31:0] hi;        // data returned for the second access
      logic [31:0] exp_instr;
      logic        exp_comp;
      logic        exp_err;
      int          exp_lat;   // cycles from pc_read_i to instr_ready_o
      int          exp_nacc;
      logic [31:0] exp_a0;
      logic [31:0] exp_a1;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " ready"}, {31'd0, instr_ready_o}, 32'd0);
      chk({tag, " req"}, {31'd0, mem_req_o}, 32'd0);
      chk({tag, " addr"}, mem_addr_o, 32'd0);
      chk({tag, " instr"}, instr_o, 32'd0);
      chk({tag, " instr_pc"}, instr_pc_o, 32'd0);
      chk({tag, " comp"}, {31'd0, is_compressed_o}, 32'd0);
      chk({tag, " err"}, {31'd0, fetch_err_o}, 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          lat;
      int          nacc;
      bit          pending;
      logic [31:0] addrs [2];
      logic [31:0] c_instr, c_pc;
      logic        c_comp, c_err;
      string       tag;
      tag      = $sformatf("v%0d", idx);
      lat      = 0;
      nacc     = 0;
      pending  = 1'b0;
      addrs[0] = '0;
      addrs[1] = '0;
      c_instr  = '0;
      c_pc     = '0;
      c_comp   = 1'b0;
      c_err    = 1'b0;
      @(negedge clk_i);
      pc_i      = v.pc;
      pc_read_i = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk_i);
         pc_read_i    = 1'b0;
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (instr_ready_o) begin
            lat     = cyc;
            c_instr = instr_o;
            c_pc    = instr_pc_o;
            c_comp  = is_compressed_o;
            c_err   = fetch_err_o;
            break;
         end
         if (pending) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = (nacc == 1) ? v.lo : v.hi;
            pending      = 1'b0;
         end else if (mem_req_o) begin
            if (nacc < 2) addrs[nacc] = mem_addr_o;
            nacc++;
            mem_gnt_i = 1'b1;
            pending   = 1'b1;
         end
      end
      chk({tag, " latency"}, lat, v.exp_lat);
      chk({tag, " instr"}, c_instr, v.exp_instr);
      chk({tag, " instr_pc"}, c_pc, v.pc);
      chk({tag, " comp"}, {31'd0, c_comp}, {31'd0, v.exp_comp});
      chk({tag, " err"}, {31'd0, c_err}, {31'd0, v.exp_err});
      chk({tag, " accesses"}, nacc, v.exp_nacc);
      if (v.exp_nacc > 0) chk({tag, " addr0"}, addrs[0], v.exp_a0);
      if (v.exp_nacc > 1) chk({tag, " addr1"}, addrs[1], v.exp_a1);
      // One cycle later: pulse gone, result held.
      @(negedge clk_i);
      chk({tag, " ready pulse width"}, {31'd0, instr_ready_o}, 32'd0);
      chk({tag, " instr held"}, instr_o, v.exp_instr);
   endtask

   initial begin
      int req_cnt;
      int rdy_cnt;
      bit got;
      logic [31:0] c_instr, c_pc;
      logic        c_err;

      vecs[0] = '{32'h0000_0000, 32'h0050_0093, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 3, 1, 32'h0000_0000, 32'h0};
      vecs[1] = '{32'h0000_0004, 32'hFFFF_4505, 32'h0, 32'h0000_4505, 1'b1, 1'b0, 3, 1, 32'h0000_0004, 32'h0};
      vecs[2] = '{32'h0000_0006, 32'h4505_1234, 32'h0, 32'h0000_4505, 1'b1, 1'b0, 3, 1, 32'h0000_0004, 32'h0};
      vecs[3] = '{32'h0000_000A, 32'h0093_ABCD, 32'h1234_0050, 32'h0050_0093, 1'b0, 1'b0, 5, 2, 32'h0000_0008, 32'h0000_000C};
      vecs[4] = '{32'h0000_0003, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 1'b1, 1, 0, 32'h0, 32'h0};
      vecs[5] = '{32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3, 1, 32'h0000_0100, 32'h0};
      vecs[6] = '{32'h0000_0012, 32'h0001_FFFF, 32'h0, 32'h0000_0001, 1'b1, 1'b0, 3, 1, 32'h0000_0010, 32'h0};

      rstn_i       = 1'b0;
      pc_i         = '0;
      pc_read_i    = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      repeat (3) @(negedge clk_i);
      chk_idle_outputs("reset");
      rstn_i = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i], i);
      end

      // Reset asserted while waiting for data: fetch abandoned, outputs cleared.
      @(negedge clk_i);
      pc_i      = 32'h0000_0040;
      pc_read_i = 1'b1;
      @(negedge clk_i);
      pc_read_i = 1'b0;
      chk("midrst req before grant", {31'd0, mem_req_o}, 32'd1);
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      rstn_i    = 1'b0;
      #1;
      chk_idle_outputs("midrst");
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0050_0093;
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      rstn_i       = 1'b1;
      rdy_cnt      = 0;
      req_cnt      = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         if (instr_ready_o) rdy_cnt++;
         if (mem_req_o) req_cnt++;
      end
      chk("midrst ready pulses", rdy_cnt, 0);
      chk("midrst req after reset", req_cnt, 0);

      // Grant never comes: request held TO cycles, then error result.
      @(negedge clk_i);
      pc_i      = 32'h0000_0020;
      pc_read_i = 1'b1;
      @(negedge clk_i);
      pc_read_i = 1'b0;
      req_cnt   = 0;
      got       = 1'b0;
      c_instr   = 32'hFFFF_FFFF;
      c_pc      = '0;
      c_err     = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (instr_ready_o) begin
            got     = 1'b1;
            c_instr = instr_o;
            c_pc    = instr_pc_o;
            c_err   = fetch_err_o;
            break;
         end
         if (mem_req_o) req_cnt++;
         // A fetch request while busy must be ignored.
         pc_read_i = (c == 10);
         pc_i      = (c == 10) ? 32'h0000_0007 : 32'h0000_0020;
         @(negedge clk_i);
         pc_read_i = 1'b0;
      end
      chk("timeout ready seen", {31'd0, got}, 32'd1);
      chk("timeout req cycles", req_cnt, TO);
      chk("timeout err", {31'd0, c_err}, 32'd1);
      chk("timeout instr", c_instr, 32'd0);
      chk("timeout instr_pc", c_pc, 32'h0000_0020);
      @(negedge clk_i);
      chk("timeout req dropped", {31'd0, mem_req_o}, 32'd0);
      chk("timeout ready pulse width", {31'd0, instr_ready_o}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_mystic_instr_fetch
